fm_wb_packer: RTL and testbench

- Per-PE-row write-back stage directly downstream of the PE matrix's fm/guard generator.
- Consumes the 8-bit feature-map byte stream (write_back_data_o/valid/fm_buf_ready) and the 6-bit guard stream (guard_o/valid/guard_buf_ready).
- Packs bytes into FM_PACK-byte SRAM words and guards into GUARD_PACK-entry words.
- Issues addressed writes to the fm buffer and guard buffer SRAM ports, then signals completion to top control.

---
 rtl/fm_wb_packer_if.sv | 76 +++++++
 rtl/fm_wb_packer.sv | 205 ++++++++++++++++++++
 tb/tb_fm_wb_packer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_wb_packer_if.sv
// fm_wb_packer_if -- bundle of all non-clock signals of the write-back packer.
//
// Groups:
//   control   : ctrl_valid/ctrl_ready start handshake, ctrl_finish pulse,
//               fm_base_i / guard_base_i start addresses
//   fm stream : wb_data_i / wb_valid_i / fm_buf_ready_o, wb_finish_i
//   guard str.: guard_i / guard_valid_i / guard_buf_ready_o
//   fm SRAM   : fm_wr_en_o / fm_wr_addr_o / fm_wr_data_o / fm_wr_gnt_i
//   guard SRAM: g_wr_en_o / g_wr_addr_o / g_wr_data_o / g_wr_gnt_i
//   debug     : dbg_state (packer FSM state)
//   optional  : stat_fm_words_o / stat_stall_o when FM_WB_PACKER_STAT_EN is defined
//
// Modports: slave = the packer, master = the surrounding environment.
//
// Handshake rule for every stream and SRAM port: a transfer happens on a
// rising clock edge where valid (or wr_en) and ready (or gnt) are both high;
// the sender keeps data/address stable while waiting.
interface fm_wb_packer_if #(
    parameter int FM_PACK    = 8,
    parameter int GUARD_PACK = 4,
    parameter int ADDR_W     = 12
);
    logic                    ctrl_valid;
    logic                    ctrl_ready;
    logic                    ctrl_finish;
    logic [ADDR_W-1:0]       fm_base_i;
    logic [ADDR_W-1:0]       guard_base_i;
    logic [7:0]              wb_data_i;
    logic                    wb_valid_i;
    logic                    fm_buf_ready_o;
    logic [5:0]              guard_i;
    logic                    guard_valid_i;
    logic                    guard_buf_ready_o;
    logic                    wb_finish_i;
    logic                    fm_wr_en_o;
    logic [ADDR_W-1:0]       fm_wr_addr_o;
    logic [8*FM_PACK-1:0]    fm_wr_data_o;
    logic                    fm_wr_gnt_i;
    logic                    g_wr_en_o;
    logic [ADDR_W-1:0]       g_wr_addr_o;
    logic [6*GUARD_PACK-1:0] g_wr_data_o;
    logic                    g_wr_gnt_i;
    logic [1:0]              dbg_state;
`ifdef FM_WB_PACKER_STAT_EN
    logic [15:0]             stat_fm_words_o;
    logic [15:0]             stat_stall_o;
`endif

    modport slave (
        input  ctrl_valid, fm_base_i, guard_base_i,
        input  wb_data_i, wb_valid_i, guard_i, guard_valid_i, wb_finish_i,
        input  fm_wr_gnt_i, g_wr_gnt_i,
        output ctrl_ready, ctrl_finish,
        output fm_buf_ready_o, guard_buf_ready_o,
        output fm_wr_en_o, fm_wr_addr_o, fm_wr_data_o,
        output g_wr_en_o, g_wr_addr_o, g_wr_data_o,
`ifdef FM_WB_PACKER_STAT_EN
        output stat_fm_words_o, stat_stall_o,
`endif
        output dbg_state
    );

    modport master (
        output ctrl_valid, fm_base_i, guard_base_i,
        output wb_data_i, wb_valid_i, guard_i, guard_valid_i, wb_finish_i,
        output fm_wr_gnt_i, g_wr_gnt_i,
        input  ctrl_ready, ctrl_finish,
        input  fm_buf_ready_o, guard_buf_ready_o,
        input  fm_wr_en_o, fm_wr_addr_o, fm_wr_data_o,
        input  g_wr_en_o, g_wr_addr_o, g_wr_data_o,
`ifdef FM_WB_PACKER_STAT_EN
        input  stat_fm_words_o, stat_stall_o,
`endif
        input  dbg_state
    );
endinterface

// File: rtl/fm_wb_packer.sv
// fm_wb_packer -- per-PE-row write-back packer.
//
// Packs the 8-bit feature-map byte stream into FM_PACK-byte SRAM words and
// the 6-bit guard stream into GUARD_PACK-entry words, writes them to
// consecutive addresses starting at the bases sampled on the start
// handshake, zero-pads and writes any partial word once the upstream
// finish pulse has been seen, then pulses ctrl_finish for one cycle.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    fm_wb_packer_if.slave (control, both input streams, both SRAM
//          write ports, FSM debug state)
//
// Optional feature: define FM_WB_PACKER_STAT_EN to add stat_fm_words_o
// (granted fm writes in the current job) and stat_stall_o (saturating count
// of cycles with fm_wr_en_o && !fm_wr_gnt_i).
module fm_wb_packer #(
    parameter int FM_PACK    = 8,
    parameter int GUARD_PACK = 4,
    parameter int ADDR_W     = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    fm_wb_packer_if.slave  bus
);
    localparam int FI_W = $clog2(FM_PACK);
    localparam int GI_W = $clog2(GUARD_PACK);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state;

    // ---------------- fm stream ----------------
    logic [FI_W-1:0]      fm_idx;
    logic [8*FM_PACK-1:0] fm_pack;
    logic [8*FM_PACK-1:0] fm_word;
    logic [8*FM_PACK-1:0] fm_wdata;
    logic [ADDR_W-1:0]    fm_waddr;
    logic [ADDR_W-1:0]    fm_addr;
    logic                 fm_pend;
    logic                 fm_last;
    logic                 fm_ready;
    logic                 fm_acc;
    logic                 fm_load;

    assign fm_last  = (fm_idx == FI_W'(FM_PACK - 1));
    // A completing byte needs the output register free; other lanes never block.
    assign fm_ready = (state == S_RUN) && !(fm_last && fm_pend);
    assign fm_acc   = bus.wb_valid_i && fm_ready;
    // Full word on last-lane accept, or zero-padded partial word during flush.
    assign fm_load  = (fm_acc && fm_last) ||
                      ((state == S_FLUSH) && (fm_idx != '0) && !fm_pend);

    // Upper lanes of fm_pack are always zero, so a flushed word is already padded.
    always_comb begin
        fm_word = fm_pack;
        if (fm_acc) begin
            fm_word[int'(fm_idx)*8 +: 8] = bus.wb_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_idx   <= '0;
            fm_pack  <= '0;
            fm_wdata <= '0;
            fm_waddr <= '0;
            fm_addr  <= '0;
            fm_pend  <= 1'b0;
        end else begin
            if ((state == S_IDLE) && bus.ctrl_valid) begin
                fm_addr <= bus.fm_base_i;
            end
            if (fm_acc && !fm_last) begin
                fm_pack <= fm_word;
                fm_idx  <= fm_idx + FI_W'(1);
            end
            if (fm_load) begin
                fm_wdata <= fm_word;
                fm_waddr <= fm_addr;
                fm_addr  <= fm_addr + ADDR_W'(1);
                fm_pack  <= '0;
                fm_idx   <= '0;
            end
            if (fm_load) begin
                fm_pend <= 1'b1;
            end else if (fm_pend && bus.fm_wr_gnt_i) begin
                fm_pend <= 1'b0;
            end
        end
    end

    // ---------------- guard stream ----------------
    logic [GI_W-1:0]         g_idx;
    logic [6*GUARD_PACK-1:0] g_pack;
    logic [6*GUARD_PACK-1:0] g_word;
    logic [6*GUARD_PACK-1:0] g_wdata;
    logic [ADDR_W-1:0]       g_waddr;
    logic [ADDR_W-1:0]       g_addr;
    logic                    g_pend;
    logic                    g_last;
    logic                    g_ready;
    logic                    g_acc;
    logic                    g_load;

    assign g_last  = (g_idx == GI_W'(GUARD_PACK - 1));
    assign g_ready = (state == S_RUN) && !(g_last && g_pend);
    assign g_acc   = bus.guard_valid_i && g_ready;
    assign g_load  = (g_acc && g_last) ||
                     ((state == S_FLUSH) && (g_idx != '0) && !g_pend);

    always_comb begin
        g_word = g_pack;
        if (g_acc) begin
            g_word[int'(g_idx)*6 +: 6] = bus.guard_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_idx   <= '0;
            g_pack  <= '0;
            g_wdata <= '0;
            g_waddr <= '0;
            g_addr  <= '0;
            g_pend  <= 1'b0;
        end else begin
            if ((state == S_IDLE) && bus.ctrl_valid) begin
                g_addr <= bus.guard_base_i;
            end
            if (g_acc && !g_last) begin
                g_pack <= g_word;
                g_idx  <= g_idx + GI_W'(1);
            end
            if (g_load) begin
                g_wdata <= g_word;
                g_waddr <= g_addr;
                g_addr  <= g_addr + ADDR_W'(1);
                g_pack  <= '0;
                g_idx   <= '0;
            end
            if (g_load) begin
                g_pend <= 1'b1;
            end else if (g_pend && bus.g_wr_gnt_i) begin
                g_pend <= 1'b0;
            end
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.ctrl_valid) state <= S_RUN;
                S_RUN:   if (bus.wb_finish_i) state <= S_FLUSH;
                S_FLUSH: if ((fm_idx == '0) && !fm_pend && (g_idx == '0) && !g_pend)
                             state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FM_WB_PACKER_STAT_EN
    logic [15:0] stat_words;
    logic [15:0] stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else if ((state == S_IDLE) && bus.ctrl_valid) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (fm_pend && bus.fm_wr_gnt_i) begin
                stat_words <= stat_words + 16'd1;
            end
            if (fm_pend && !bus.fm_wr_gnt_i && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end

    assign bus.stat_fm_words_o = stat_words;
    assign bus.stat_stall_o    = stat_stall;
`endif

    assign bus.ctrl_ready        = (state == S_IDLE);
    assign bus.ctrl_finish       = (state == S_DONE);
    assign bus.fm_buf_ready_o    = fm_ready;
    assign bus.guard_buf_ready_o = g_ready;
    assign bus.fm_wr_en_o        = fm_pend;
    assign bus.fm_wr_addr_o      = fm_waddr;
    assign bus.fm_wr_data_o      = fm_wdata;
    assign bus.g_wr_en_o         = g_pend;
    assign bus.g_wr_addr_o       = g_waddr;
    assign bus.g_wr_data_o       = g_wdata;
    assign bus.dbg_state         = state;
endmodule

// File: tb/tb_fm_wb_packer.sv
// tb_fm_wb_packer -- self-checking bench for fm_wb_packer.
// Drivers feed the two streams with $urandom gaps; expected SRAM writes are
// computed from the byte/entry lists when a job is issued and queued; a
// negedge monitor pops and compares on every granted write, checks stall
// stability and checks input-ready against a word-count model.
module tb_fm_wb_packer;
    localparam int FM_PACK    = 8;
    localparam int GUARD_PACK = 4;
    localparam int ADDR_W     = 12;
    localparam int FW = 8 * FM_PACK;
    localparam int GW = 6 * GUARD_PACK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fm_wb_packer_if #(.FM_PACK(FM_PACK), .GUARD_PACK(GUARD_PACK), .ADDR_W(ADDR_W)) bus();

    fm_wb_packer #(.FM_PACK(FM_PACK), .GUARD_PACK(GUARD_PACK), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [ADDR_W+FW-1:0] fm_exp_q[$];
    logic [ADDR_W+GW-1:0] g_exp_q[$];
    logic [7:0] fm_bytes[$];
    logic [5:0] g_ents[$];

    int gmode_fm = 0;
    int gmode_g = 0;
    int stall_left = 0;
    int win_left = 0;
    bit win_started = 1'b0;
    int finish_cnt = 0;

    // reference model of the job, advanced at every negedge
    bit run_m = 1'b0;
    int fm_acc_m, g_acc_m, fm_wr_m, g_wr_m;
    bit fm_hold = 1'b0, g_hold = 1'b0;
    logic [ADDR_W+FW-1:0] fm_prev;
    logic [ADDR_W+GW-1:0] g_prev;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected words: chunk the list, zero-pad the tail, addresses wrap mod 2^ADDR_W
    task automatic push_fm_model(input logic [ADDR_W-1:0] base);
        int n = fm_bytes.size();
        for (int w = 0; w < (n + FM_PACK - 1) / FM_PACK; w++) begin
            logic [FW-1:0] d = '0;
            logic [ADDR_W-1:0] a = ADDR_W'(int'(base) + w);
            for (int k = 0; k < FM_PACK; k++)
                if (w * FM_PACK + k < n) d[k*8 +: 8] = fm_bytes[w*FM_PACK + k];
            fm_exp_q.push_back({a, d});
        end
    endtask

    task automatic push_g_model(input logic [ADDR_W-1:0] base);
        int n = g_ents.size();
        for (int w = 0; w < (n + GUARD_PACK - 1) / GUARD_PACK; w++) begin
            logic [GW-1:0] d = '0;
            logic [ADDR_W-1:0] a = ADDR_W'(int'(base) + w);
            for (int k = 0; k < GUARD_PACK; k++)
                if (w * GUARD_PACK + k < n) d[k*6 +: 6] = g_ents[w*GUARD_PACK + k];
            g_exp_q.push_back({a, d});
        end
    endtask

    // ---------------- grant generator ----------------
    initial begin
        bus.fm_wr_gnt_i = 1'b0;
        bus.g_wr_gnt_i  = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (gmode_fm)
                0: bus.fm_wr_gnt_i = 1'b1;
                1: bus.fm_wr_gnt_i = 1'($urandom_range(0, 1));
                2: bus.fm_wr_gnt_i = 1'b0;
                3: begin
                    if (bus.fm_wr_en_o && stall_left > 0) begin
                        bus.fm_wr_gnt_i = 1'b0;
                        stall_left--;
                    end else bus.fm_wr_gnt_i = 1'b1;
                end
                default: begin
                    if (!win_started && bus.fm_wr_en_o) begin
                        win_started = 1'b1;
                        win_left = 10;
                    end
                    if (win_left > 0) begin
                        bus.fm_wr_gnt_i = 1'b0;
                        win_left--;
                    end else bus.fm_wr_gnt_i = 1'b1;
                end
            endcase
            bus.g_wr_gnt_i = (gmode_g == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            run_m = 1'b0;
            fm_hold = 1'b0;
            g_hold = 1'b0;
        end else begin
            check("fm_ready", bus.fm_buf_ready_o,
                  run_m && !((fm_acc_m % FM_PACK == FM_PACK - 1) && (fm_acc_m / FM_PACK > fm_wr_m)));
            check("g_ready", bus.guard_buf_ready_o,
                  run_m && !((g_acc_m % GUARD_PACK == GUARD_PACK - 1) && (g_acc_m / GUARD_PACK > g_wr_m)));
            if (fm_hold)
                check("fm_stall_stable", {bus.fm_wr_en_o, bus.fm_wr_addr_o, bus.fm_wr_data_o}, {1'b1, fm_prev});
            if (g_hold)
                check("g_stall_stable", {bus.g_wr_en_o, bus.g_wr_addr_o, bus.g_wr_data_o}, {1'b1, g_prev});
            if (bus.fm_wr_en_o && bus.fm_wr_gnt_i) begin
                if (fm_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL fm_wr_unexpected: got addr %0h data %0h expected no write",
                             bus.fm_wr_addr_o, bus.fm_wr_data_o);
                end else check("fm_wr", {bus.fm_wr_addr_o, bus.fm_wr_data_o}, fm_exp_q.pop_front());
            end
            if (bus.g_wr_en_o && bus.g_wr_gnt_i) begin
                if (g_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL g_wr_unexpected: got addr %0h data %0h expected no write",
                             bus.g_wr_addr_o, bus.g_wr_data_o);
                end else check("g_wr", {bus.g_wr_addr_o, bus.g_wr_data_o}, g_exp_q.pop_front());
            end
            fm_hold = bus.fm_wr_en_o && !bus.fm_wr_gnt_i;
            g_hold  = bus.g_wr_en_o && !bus.g_wr_gnt_i;
            fm_prev = {bus.fm_wr_addr_o, bus.fm_wr_data_o};
            g_prev  = {bus.g_wr_addr_o, bus.g_wr_data_o};
            if (bus.ctrl_finish) finish_cnt++;
            if (run_m) begin
                if (bus.wb_valid_i && bus.fm_buf_ready_o) fm_acc_m++;
                if (bus.guard_valid_i && bus.guard_buf_ready_o) g_acc_m++;
                if (bus.wb_finish_i) run_m = 1'b0;
            end else if (bus.ctrl_valid && bus.ctrl_ready) begin
                run_m = 1'b1;
                fm_acc_m = 0; g_acc_m = 0; fm_wr_m = 0; g_wr_m = 0;
            end
            if (bus.fm_wr_en_o && bus.fm_wr_gnt_i) fm_wr_m++;
            if (bus.g_wr_en_o && bus.g_wr_gnt_i) g_wr_m++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [ADDR_W-1:0] fb, input logic [ADDR_W-1:0] gb);
        int c = 0;
        @(posedge clk); #1;
        while (!bus.ctrl_ready && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 200) check("ctrl_ready_timeout", 0, 1);
        bus.ctrl_valid   = 1'b1;
        bus.fm_base_i    = fb;
        bus.guard_base_i = gb;
        @(posedge clk); #1;
        bus.ctrl_valid = 1'b0;
    endtask

    task automatic drive_fm(input bit gap, input bit coinc);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < fm_bytes.size() && cyc < 3000) begin
            if (!bus.wb_valid_i) bus.wb_valid_i = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.wb_data_i = fm_bytes[i];
            acc = bus.wb_valid_i && bus.fm_buf_ready_o;
            if (coinc && acc && i == fm_bytes.size() - 1) bus.wb_finish_i = 1'b1;
            @(posedge clk); #1;
            bus.wb_finish_i = 1'b0;
            if (acc) begin
                i++;
                bus.wb_valid_i = 1'b0;
            end
            cyc++;
        end
        bus.wb_valid_i = 1'b0;
        if (i < fm_bytes.size()) check("fm_drive_timeout", i, fm_bytes.size());
    endtask

    task automatic drive_g(input bit gap);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < g_ents.size() && cyc < 3000) begin
            if (!bus.guard_valid_i) bus.guard_valid_i = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.guard_i = g_ents[i];
            acc = bus.guard_valid_i && bus.guard_buf_ready_o;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                bus.guard_valid_i = 1'b0;
            end
            cyc++;
        end
        bus.guard_valid_i = 1'b0;
        if (i < g_ents.size()) check("g_drive_timeout", i, g_ents.size());
    endtask

    task automatic wait_done();
        int c = 0;
        while (!bus.ctrl_finish && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) check("ctrl_finish_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("finish_pulses", finish_cnt, 1);
        check("fm_q_empty", fm_exp_q.size(), 0);
        check("g_q_empty", g_exp_q.size(), 0);
        check("ctrl_ready_idle", bus.ctrl_ready, 1);
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] fb, input logic [ADDR_W-1:0] gb,
                           input bit gap, input bit coinc, input int gmf, input int gmg);
        gmode_fm = gmf;
        gmode_g = gmg;
        stall_left = 3;
        win_started = 1'b0;
        win_left = 0;
        finish_cnt = 0;
        start_job(fb, gb);
        fork
            drive_fm(gap, coinc);
            drive_g(gap);
        join
        if (!coinc) begin
            bus.wb_finish_i = 1'b1;
            @(posedge clk); #1;
            bus.wb_finish_i = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end expected end of run");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ctrl_valid = 1'b0;
        bus.fm_base_i = '0;
        bus.guard_base_i = '0;
        bus.wb_data_i = '0;
        bus.wb_valid_i = 1'b0;
        bus.guard_i = '0;
        bus.guard_valid_i = 1'b0;
        bus.wb_finish_i = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl_ready", bus.ctrl_ready, 1);
        check("rst_outputs", {bus.ctrl_finish, bus.fm_buf_ready_o, bus.guard_buf_ready_o,
                              bus.fm_wr_en_o, bus.g_wr_en_o, bus.fm_wr_addr_o, bus.g_wr_addr_o}, 0);
        check("rst_data", {bus.fm_wr_data_o, bus.g_wr_data_o}, 0);
        rst_n = 1'b1;

        // basic pack
        fm_bytes.delete(); g_ents.delete();
        for (int i = 0; i < 16; i++) fm_bytes.push_back(8'(i));
        fm_exp_q.push_back({12'h010, 64'h0706050403020100});
        fm_exp_q.push_back({12'h011, 64'h0F0E0D0C0B0A0908});
        run_job(12'h010, 12'h000, 1'b0, 1'b0, 0, 0);

        // partial flush with guards
        fm_bytes.delete(); g_ents.delete();
        for (int i = 0; i < 11; i++) fm_bytes.push_back(8'(8'hA0 + i));
        for (int i = 1; i <= 5; i++) g_ents.push_back(6'(i));
        fm_exp_q.push_back({12'h000, 64'hA7A6A5A4A3A2A1A0});
        fm_exp_q.push_back({12'h001, 64'h0000000000AAA9A8});
        g_exp_q.push_back({12'h000, 6'h04, 6'h03, 6'h02, 6'h01});
        g_exp_q.push_back({12'h001, 24'h000005});
        run_job(12'h000, 12'h000, 1'b0, 1'b0, 0, 0);

        // backpressure: grant withheld for 10 cycles after the first word
        fm_bytes.delete(); g_ents.delete();
        for (int i = 0; i < 16; i++) fm_bytes.push_back(8'($urandom_range(0, 255)));
        push_fm_model(12'h040);
        run_job(12'h040, 12'h000, 1'b0, 1'b0, 4, 0);

        // address wrap, finish coincident with last byte
        fm_bytes.delete(); g_ents.delete();
        for (int i = 0; i < 16; i++) fm_bytes.push_back(8'($urandom_range(0, 255)));
        push_fm_model(12'hFFF);
        run_job(12'hFFF, 12'h000, 1'b0, 1'b1, 0, 0);

        // reset mid-job with a write pending and no grant
        fm_bytes.delete(); g_ents.delete();
        for (int i = 0; i < 8; i++) fm_bytes.push_back(8'(8'h50 + i));
        gmode_fm = 2;
        gmode_g = 0;
        start_job(12'h100, 12'h000);
        drive_fm(1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_pend", bus.fm_wr_en_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drops_wr_en", bus.fm_wr_en_o, 0);
        check("rst_ctrl_ready", bus.ctrl_ready, 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ctrl_ready", bus.ctrl_ready, 1);
        check("post_rst_wr_en", bus.fm_wr_en_o, 0);
        fm_bytes.delete();
        for (int i = 0; i < 16; i++) fm_bytes.push_back(8'($urandom_range(0, 255)));
        push_fm_model(12'h020);
        run_job(12'h020, 12'h000, 1'b0, 1'b0, 0, 0);

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            logic [ADDR_W-1:0] fb = ADDR_W'($urandom_range(0, 4095));
            logic [ADDR_W-1:0] gb = ADDR_W'($urandom_range(0, 4095));
            int nf = $urandom_range(0, 40);
            int ng = $urandom_range(0, 20);
            fm_bytes.delete(); g_ents.delete();
            for (int i = 0; i < nf; i++) fm_bytes.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < ng; i++) g_ents.push_back(6'($urandom_range(0, 63)));
            push_fm_model(fb);
            push_g_model(gb);
            run_job(fb, gb, 1'b1, 1'b0, 1, 1);
        end

`ifdef FM_WB_PACKER_STAT_EN
        // statistics: 24 bytes, 3 stall cycles
        fm_bytes.delete(); g_ents.delete();
        for (int i = 0; i < 24; i++) fm_bytes.push_back(8'($urandom_range(0, 255)));
        push_fm_model(12'h200);
        run_job(12'h200, 12'h000, 1'b0, 1'b0, 3, 0);
        check("stat_fm_words", bus.stat_fm_words_o, 3);
        check("stat_stall", bus.stat_stall_o, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
